alu_seq: RTL and testbench

ALU_SEQ -- requirements
Module: alu_seq

---
 rtl/alu_seq.sv | 287 ++++++++++++++++++++++++++++
 tb/tb_alu_seq.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// alu_seq: sequential ALU. Logic and arithmetic ops, shifts and illegal ops finish in one cycle.
// Signed multiply runs as iterative Booth (or single-cycle), and unsigned divide is restoring.
module alu_seq #(
  parameter int W        = 16,
  parameter int MUL_ITER = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [3:0]   op,
  input  logic         c7,
  input  logic         c14,
  input  logic [W-1:0] acc_in,
  input  logic [W-1:0] y_in,
  input  logic [W-1:0] mr_in,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] result,
  output logic [W-1:0] mr_out,
  output logic         err
);

  localparam int CW = $clog2(W);
  localparam logic [CW-1:0] CNT_LAST = CW'(W - 1);
  localparam logic MUL_SEQ = (MUL_ITER != 0);

  localparam logic [3:0] OP_PASSY = 4'd0;
  localparam logic [3:0] OP_ADD   = 4'd1;
  localparam logic [3:0] OP_SUB   = 4'd2;
  localparam logic [3:0] OP_MUL   = 4'd3;
  localparam logic [3:0] OP_DIV   = 4'd4;
  localparam logic [3:0] OP_AND   = 4'd5;
  localparam logic [3:0] OP_OR    = 4'd6;
  localparam logic [3:0] OP_NOTY  = 4'd7;
  localparam logic [3:0] OP_SHR   = 4'd8;
  localparam logic [3:0] OP_SHL   = 4'd9;
  localparam logic [3:0] OP_NOTX  = 4'd10;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nx;

  logic [3:0]    r_op;
  logic [CW-1:0] r_cnt;
  logic [W:0]    r_a;
  logic [W-1:0]  r_q;
  logic [W-1:0]  r_m;
  logic          r_q1;
  logic          r_busy;
  logic          r_done;
  logic          r_err;
  logic [W-1:0]  r_result;
  logic [W-1:0]  r_mr_out;

  logic [W-1:0]  w_x;
  logic [W-1:0]  w_y;
  logic          w_accept;
  logic          w_iter_op;
  logic          w_last;

  logic [2*W-1:0] w_cat;
  logic [2*W-1:0] w_prod;
  logic [W-1:0]   w_sc_res;
  logic [W-1:0]   w_sc_mr;
  logic           w_sc_err;
  logic           w_sext;

  logic [W:0]    w_bm;
  logic [W:0]    w_ba;
  logic [W:0]    w_b_a;
  logic [W-1:0]  w_b_q;
  logic          w_b_q1;
  logic [W:0]    w_d_sh;
  logic [W:0]    w_d_sub;
  logic [W:0]    w_d_a;
  logic [W-1:0]  w_d_q;

  logic [3:0]    w_op_nx;
  logic [CW-1:0] w_cnt_nx;
  logic [W:0]    w_a_nx;
  logic [W-1:0]  w_q_nx;
  logic [W-1:0]  w_m_nx;
  logic          w_q1_nx;
  logic [W-1:0]  w_res_nx;
  logic [W-1:0]  w_mr_nx;
  logic          w_err_nx;
  logic          w_busy_nx;
  logic          w_done_nx;

  assign w_x       = c7  ? acc_in : {W{1'b0}};
  assign w_y       = c14 ? y_in   : {W{1'b0}};
  assign w_accept  = start && (r_state == S_IDLE);
  assign w_iter_op = ((op == OP_MUL) && MUL_SEQ) || ((op == OP_DIV) && (w_y != {W{1'b0}}));
  assign w_last    = (r_cnt == CNT_LAST);
  assign w_cat     = {mr_in, w_x};
  assign w_prod    = $signed({{W{w_x[W-1]}}, w_x}) * $signed({{W{w_y[W-1]}}, w_y});

  always_comb begin
    w_sc_res = {W{1'b0}};
    w_sc_mr  = {W{1'b0}};
    w_sc_err = 1'b0;
    w_sext   = 1'b1;
    case (op)
      OP_PASSY: w_sc_res = w_y;
      OP_ADD:   w_sc_res = w_x + w_y;
      OP_SUB:   w_sc_res = w_x - w_y;
      OP_AND:   w_sc_res = w_x & w_y;
      OP_OR:    w_sc_res = w_x | w_y;
      OP_NOTY:  w_sc_res = ~w_y;
      OP_NOTX:  w_sc_res = ~w_x;
      OP_MUL: begin
        {w_sc_mr, w_sc_res} = w_prod;
        w_sext = 1'b0;
      end
      // Only reached for a zero divisor; real divides take the iterative path.
      OP_DIV: begin
        w_sc_res = {W{1'b1}};
        w_sc_mr  = w_x;
        w_sc_err = 1'b1;
        w_sext   = 1'b0;
      end
      OP_SHR: begin
        {w_sc_mr, w_sc_res} = w_cat >> 1'b1;
        w_sext = 1'b0;
      end
      OP_SHL: begin
        {w_sc_mr, w_sc_res} = w_cat << 1'b1;
        w_sext = 1'b0;
      end
      default: begin
        w_sc_err = 1'b1;
        w_sext   = 1'b0;
      end
    endcase
    if (w_sext) begin
      w_sc_mr = {W{w_sc_res[W-1]}};
    end else begin
      w_sc_mr = w_sc_mr;
    end
  end

  // One radix-2 Booth step and one restoring-divide step, both from the working registers.
  always_comb begin
    w_bm = {r_m[W-1], r_m};
    case ({r_q[0], r_q1})
      2'b01:   w_ba = r_a + w_bm;
      2'b10:   w_ba = r_a - w_bm;
      default: w_ba = r_a;
    endcase
    {w_b_a, w_b_q, w_b_q1} = {w_ba[W], w_ba, r_q};

    w_d_sh  = {r_a[W-1:0], r_q[W-1]};
    w_d_sub = w_d_sh - {1'b0, r_m};
    if (w_d_sub[W]) begin
      w_d_a = w_d_sh;
      w_d_q = {r_q[W-2:0], 1'b0};
    end else begin
      w_d_a = w_d_sub;
      w_d_q = {r_q[W-2:0], 1'b1};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nx;
    end
  end

  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_state_nx = w_iter_op ? S_RUN : S_DONE;
        end else begin
          w_state_nx = S_IDLE;
        end
      end
      S_RUN:   w_state_nx = w_last ? S_DONE : S_RUN;
      S_DONE:  w_state_nx = S_IDLE;
      default: w_state_nx = S_IDLE;
    endcase
  end

  // Visible results change only when an operation finishes, never mid-iteration.
  always_comb begin
    w_op_nx  = r_op;
    w_cnt_nx = r_cnt;
    w_a_nx   = r_a;
    w_q_nx   = r_q;
    w_m_nx   = r_m;
    w_q1_nx  = r_q1;
    w_res_nx = r_result;
    w_mr_nx  = r_mr_out;
    w_err_nx = r_err;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_op_nx  = op;
          w_cnt_nx = {CW{1'b0}};
          w_a_nx   = {(W+1){1'b0}};
          w_q_nx   = w_x;
          w_m_nx   = w_y;
          w_q1_nx  = 1'b0;
          if (!w_iter_op) begin
            w_res_nx = w_sc_res;
            w_mr_nx  = w_sc_mr;
            w_err_nx = w_sc_err;
          end else begin
            w_err_nx = r_err;
          end
        end else begin
          w_cnt_nx = r_cnt;
        end
      end
      S_RUN: begin
        w_cnt_nx = r_cnt + 1'b1;
        if (r_op == OP_MUL) begin
          w_a_nx  = w_b_a;
          w_q_nx  = w_b_q;
          w_q1_nx = w_b_q1;
        end else begin
          w_a_nx  = w_d_a;
          w_q_nx  = w_d_q;
        end
        if (w_last) begin
          w_err_nx = 1'b0;
          if (r_op == OP_MUL) begin
            w_mr_nx  = w_b_a[W-1:0];
            w_res_nx = w_b_q;
          end else begin
            w_mr_nx  = w_d_a[W-1:0];
            w_res_nx = w_d_q;
          end
        end else begin
          w_err_nx = r_err;
        end
      end
      S_DONE:  w_cnt_nx = r_cnt;
      default: w_cnt_nx = {CW{1'b0}};
    endcase
    w_busy_nx = (w_state_nx == S_RUN);
    w_done_nx = (w_state_nx == S_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op     <= 4'd0;
      r_cnt    <= {CW{1'b0}};
      r_a      <= {(W+1){1'b0}};
      r_q      <= {W{1'b0}};
      r_m      <= {W{1'b0}};
      r_q1     <= 1'b0;
      r_result <= {W{1'b0}};
      r_mr_out <= {W{1'b0}};
      r_err    <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_op     <= w_op_nx;
      r_cnt    <= w_cnt_nx;
      r_a      <= w_a_nx;
      r_q      <= w_q_nx;
      r_m      <= w_m_nx;
      r_q1     <= w_q1_nx;
      r_result <= w_res_nx;
      r_mr_out <= w_mr_nx;
      r_err    <= w_err_nx;
      r_busy   <= w_busy_nx;
      r_done   <= w_done_nx;
    end
  end

  assign busy   = r_busy;
  assign done   = r_done;
  assign result = r_result;
  assign mr_out = r_mr_out;
  assign err    = r_err;

endmodule

// File: tb/tb_alu_seq.sv
// Randomized and directed bench for alu_seq (W=16, iterative multiply) against an arithmetic model.
module tb_alu_seq;
  localparam int W = 16;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [3:0]   op;
  logic         c7;
  logic         c14;
  logic [W-1:0] acc_in;
  logic [W-1:0] y_in;
  logic [W-1:0] mr_in;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic [W-1:0] mr_out;
  logic         err;

  int n_pass  = 0;
  int n_total = 0;

  alu_seq #(.W(W), .MUL_ITER(1)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .c7(c7), .c14(c14),
    .acc_in(acc_in), .y_in(y_in), .mr_in(mr_in), .busy(busy), .done(done),
    .result(result), .mr_out(mr_out), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: returns {err, mr_out, result} from gated operands.
  function automatic logic [32:0] model(input logic [3:0] o, input logic [15:0] x, input logic [15:0] y,
                                        input logic [15:0] m);
    logic [15:0] r;
    logic [15:0] h;
    logic        e;
    logic [31:0] cat;
    longint      p;
    r = 16'd0; h = 16'd0; e = 1'b0;
    case (o)
      4'd0:  r = y;
      4'd1:  r = x + y;
      4'd2:  r = x - y;
      4'd5:  r = x & y;
      4'd6:  r = x | y;
      4'd7:  r = ~y;
      4'd10: r = ~x;
      4'd3: begin
        p = longint'($signed(x)) * longint'($signed(y));
        {h, r} = p[31:0];
      end
      4'd4: begin
        if (y == 16'd0) begin r = 16'hFFFF; h = x; e = 1'b1; end
        else begin r = x / y; h = x % y; end
      end
      4'd8: begin cat = {m, x}; cat = cat >> 1; {h, r} = cat; end
      4'd9: begin cat = {m, x}; cat = cat << 1; {h, r} = cat; end
      default: e = 1'b1;
    endcase
    if (o inside {4'd0, 4'd1, 4'd2, 4'd5, 4'd6, 4'd7, 4'd10}) h = r[15] ? 16'hFFFF : 16'h0000;
    return {e, h, r};
  endfunction

  function automatic int model_lat(input logic [3:0] o, input logic [15:0] y);
    return (o == 4'd3 || (o == 4'd4 && y != 16'd0)) ? W + 1 : 1;
  endfunction

  task automatic launch(input logic [3:0] o, input logic g7, input logic g14,
                        input logic [15:0] a, input logic [15:0] b, input logic [15:0] m);
    @(negedge clk);
    start = 1'b1; op = o; c7 = g7; c14 = g14; acc_in = a; y_in = b; mr_in = m;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    op = 4'($urandom); c7 = 1'($urandom); c14 = 1'($urandom);
    acc_in = 16'($urandom); y_in = 16'($urandom); mr_in = 16'($urandom);
  endtask

  task automatic wait_done(input int lat0, output int lat, output int nbusy);
    lat = lat0; nbusy = 0;
    while (done !== 1'b1 && lat < 200) begin
      if (busy === 1'b1) nbusy++;
      @(negedge clk);
      lat++;
    end
    if (done !== 1'b1) lat = -1;
  endtask

  task automatic run_op(input logic [3:0] o, input logic g7, input logic g14,
                        input logic [15:0] a, input logic [15:0] b, input logic [15:0] m,
                        output int lat, output int nbusy, output logic [32:0] obs);
    launch(o, g7, g14, a, b, m);
    wait_done(1, lat, nbusy);
    obs = {err, mr_out, result};
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; op = 4'd0; c7 = 1'b0; c14 = 1'b0;
    acc_in = 16'd0; y_in = 16'd0; mr_in = 16'd0;
    repeat (3) @(negedge clk);
    n_total++;
    if ({busy, done, err, result, mr_out} !== 35'd0) $display("FAIL reset_state: got %h want 0", {busy, done, err, result, mr_out});
    else n_pass++;
    rst_n = 1'b1;
  endtask

  task automatic test_add();
    int lat, nb; logic [32:0] obs;
    run_op(4'd1, 1'b1, 1'b1, 16'h7FFF, 16'h0001, 16'h0000, lat, nb, obs);
    n_total++; if (lat !== 1) $display("FAIL add_lat: got %0d want 1", lat); else n_pass++;
    n_total++; if (obs !== {1'b0, 16'hFFFF, 16'h8000}) $display("FAIL add_val: got %h want %h", obs, {1'b0, 16'hFFFF, 16'h8000}); else n_pass++;
  endtask

  task automatic test_mul();
    int lat, nb; logic [32:0] obs;
    run_op(4'd3, 1'b1, 1'b1, 16'hFFFD, 16'h0007, 16'h0000, lat, nb, obs);
    n_total++; if (lat !== 17) $display("FAIL mul_lat: got %0d want 17", lat); else n_pass++;
    n_total++; if (nb !== 16) $display("FAIL mul_busy: got %0d want 16", nb); else n_pass++;
    n_total++; if (obs !== {1'b0, 32'hFFFF_FFEB}) $display("FAIL mul_val: got %h want %h", obs, {1'b0, 32'hFFFF_FFEB}); else n_pass++;
    run_op(4'd3, 1'b1, 1'b1, 16'h8000, 16'h8000, 16'h0000, lat, nb, obs);
    n_total++; if (obs !== {1'b0, 32'h4000_0000}) $display("FAIL mul_minmin: got %h want %h", obs, {1'b0, 32'h4000_0000}); else n_pass++;
  endtask

  task automatic test_div();
    int lat, nb; logic [32:0] obs;
    run_op(4'd4, 1'b1, 1'b1, 16'd100, 16'd7, 16'h0000, lat, nb, obs);
    n_total++; if (lat !== 17) $display("FAIL div_lat: got %0d want 17", lat); else n_pass++;
    n_total++; if (obs !== {1'b0, 16'd2, 16'd14}) $display("FAIL div_val: got %h want %h", obs, {1'b0, 16'd2, 16'd14}); else n_pass++;
    run_op(4'd4, 1'b1, 1'b1, 16'd100, 16'd0, 16'h0000, lat, nb, obs);
    n_total++; if (lat !== 1) $display("FAIL div0_lat: got %0d want 1", lat); else n_pass++;
    n_total++; if (obs !== {1'b1, 16'd100, 16'hFFFF}) $display("FAIL div0_val: got %h want %h", obs, {1'b1, 16'd100, 16'hFFFF}); else n_pass++;
    run_op(4'd4, 1'b1, 1'b1, 16'hFFFF, 16'd1, 16'h0000, lat, nb, obs);
    n_total++; if (obs !== {1'b0, 16'd0, 16'hFFFF}) $display("FAIL div_unsigned: got %h want %h", obs, {1'b0, 16'd0, 16'hFFFF}); else n_pass++;
  endtask

  task automatic test_shift();
    int lat, nb; logic [32:0] obs;
    run_op(4'd8, 1'b1, 1'b1, 16'h8000, 16'h1234, 16'h0001, lat, nb, obs);
    n_total++; if (obs !== {1'b0, 16'h0000, 16'hC000}) $display("FAIL shr_val: got %h want %h", obs, {1'b0, 16'h0000, 16'hC000}); else n_pass++;
    run_op(4'd9, 1'b1, 1'b1, 16'h8000, 16'h1234, 16'h0001, lat, nb, obs);
    n_total++; if (obs !== {1'b0, 16'h0003, 16'h0000}) $display("FAIL shl_val: got %h want %h", obs, {1'b0, 16'h0003, 16'h0000}); else n_pass++;
  endtask

  task automatic test_gating_illegal();
    int lat, nb; logic [32:0] obs;
    run_op(4'd1, 1'b0, 1'b1, 16'h1234, 16'd5, 16'h0000, lat, nb, obs);
    n_total++; if (obs !== {1'b0, 16'h0000, 16'h0005}) $display("FAIL gate_x: got %h want %h", obs, {1'b0, 16'h0000, 16'h0005}); else n_pass++;
    run_op(4'd0, 1'b1, 1'b0, 16'h1234, 16'h8005, 16'h0000, lat, nb, obs);
    n_total++; if (obs !== {1'b0, 16'h0000, 16'h0000}) $display("FAIL gate_y: got %h want 0", obs); else n_pass++;
    run_op(4'd13, 1'b1, 1'b1, 16'h1234, 16'd5, 16'h0000, lat, nb, obs);
    n_total++; if (lat !== 1) $display("FAIL illegal_lat: got %0d want 1", lat); else n_pass++;
    n_total++; if (obs !== {1'b1, 32'd0}) $display("FAIL illegal_val: got %h want %h", obs, {1'b1, 32'd0}); else n_pass++;
    @(negedge clk);
    n_total++; if (done !== 1'b0) $display("FAIL illegal_pulse: got %b want 0", done); else n_pass++;
  endtask

  task automatic test_busy_protect();
    int lat, nb, seen;
    launch(4'd4, 1'b1, 1'b1, 16'd100, 16'd7, 16'h0000);
    repeat (3) @(negedge clk);
    start = 1'b1; op = 4'd1; c7 = 1'b1; c14 = 1'b1; acc_in = 16'd1; y_in = 16'd1;
    @(negedge clk);
    start = 1'b0;
    wait_done(5, lat, nb);
    n_total++; if (lat !== 17) $display("FAIL busy_lat: got %0d want 17", lat); else n_pass++;
    n_total++; if ({err, mr_out, result} !== {1'b0, 16'd2, 16'd14}) $display("FAIL busy_val: got %h want %h", {err, mr_out, result}, {1'b0, 16'd2, 16'd14}); else n_pass++;
    seen = 0;
    repeat (4) begin @(negedge clk); if (done === 1'b1) seen++; end
    n_total++; if (seen !== 0) $display("FAIL busy_noqueue: got %0d done pulses want 0", seen); else n_pass++;
    n_total++; if ({err, mr_out, result} !== {1'b0, 16'd2, 16'd14}) $display("FAIL busy_hold: got %h want %h", {err, mr_out, result}, {1'b0, 16'd2, 16'd14}); else n_pass++;
  endtask

  task automatic test_reset_during_run();
    int lat, nb, seen; logic [32:0] obs;
    launch(4'd4, 1'b1, 1'b1, 16'd100, 16'd7, 16'h0000);
    repeat (7) @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_total++;
    if ({busy, done, err, result, mr_out} !== 35'd0) $display("FAIL rst_run_state: got %h want 0", {busy, done, err, result, mr_out});
    else n_pass++;
    seen = 0;
    repeat (2) begin @(negedge clk); if (done === 1'b1) seen++; end
    rst_n = 1'b1;
    repeat (20) begin @(negedge clk); if (done === 1'b1) seen++; end
    n_total++; if (seen !== 0) $display("FAIL rst_run_nodone: got %0d want 0", seen); else n_pass++;
    run_op(4'd1, 1'b1, 1'b1, 16'h7FFF, 16'h0001, 16'h0000, lat, nb, obs);
    n_total++; if (lat !== 1 || obs !== {1'b0, 16'hFFFF, 16'h8000}) $display("FAIL rst_run_next: got lat %0d val %h want lat 1 val %h", lat, obs, {1'b0, 16'hFFFF, 16'h8000}); else n_pass++;
  endtask

  task automatic test_back_to_back();
    int lat, nb; logic [32:0] obs;
    run_op(4'd1, 1'b1, 1'b1, 16'd3, 16'd4, 16'h0000, lat, nb, obs);
    n_total++; if (obs !== {1'b0, 16'h0000, 16'd7}) $display("FAIL b2b_add: got %h want %h", obs, {1'b0, 16'h0000, 16'd7}); else n_pass++;
    run_op(4'd2, 1'b1, 1'b1, 16'd3, 16'd4, 16'h0000, lat, nb, obs);
    n_total++; if (lat !== 1 || obs !== {1'b1 ^ 1'b1, 16'hFFFF, 16'hFFFF}) $display("FAIL b2b_sub: got lat %0d val %h want lat 1 val %h", lat, obs, {1'b0, 32'hFFFF_FFFF}); else n_pass++;
    run_op(4'd3, 1'b1, 1'b1, 16'd300, 16'hFFFE, 16'h0000, lat, nb, obs);
    n_total++; if (lat !== 17 || obs !== {1'b0, 32'hFFFF_FDA8}) $display("FAIL b2b_mul: got lat %0d val %h want lat 17 val %h", lat, obs, {1'b0, 32'hFFFF_FDA8}); else n_pass++;
    repeat (3) @(negedge clk);
    n_total++; if ({done, err, mr_out, result} !== {2'b00, 32'hFFFF_FDA8}) $display("FAIL b2b_hold: got %h want %h", {done, err, mr_out, result}, {2'b00, 32'hFFFF_FDA8}); else n_pass++;
  endtask

  task automatic test_random();
    int lat, nb, elat;
    logic [32:0] obs, exp;
    logic [3:0]  o;
    logic        g7, g14;
    logic [15:0] a, b, m, x, y;
    for (int i = 0; i < 60; i++) begin
      o   = 4'($urandom_range(0, 15));
      g7  = ($urandom_range(0, 7) != 0);
      g14 = ($urandom_range(0, 7) != 0);
      a   = 16'($urandom);
      b   = 16'($urandom);
      m   = 16'($urandom);
      if ($urandom_range(0, 4) == 0) a = 16'h8000;
      if (o == 4'd4 && $urandom_range(0, 3) == 0) b = 16'd0;
      x = g7 ? a : 16'd0;
      y = g14 ? b : 16'd0;
      exp  = model(o, x, y, m);
      elat = model_lat(o, y);
      run_op(o, g7, g14, a, b, m, lat, nb, obs);
      n_total++; if (lat !== elat) $display("FAIL rand_lat[%0d] op %0d: got %0d want %0d", i, o, lat, elat); else n_pass++;
      n_total++; if (obs !== exp) $display("FAIL rand_val[%0d] op %0d x %h y %h: got %h want %h", i, o, x, y, obs, exp); else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_mul();
    test_div();
    test_shift();
    test_gating_illegal();
    test_busy_protect();
    test_reset_during_run();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
